rmt_egress_pkt_buffer: RTL
==========================

Name: rmt_egress_pkt_buffer

Overview:
- Store-and-forward packet buffer directly downstream of the RMT pipeline's deparser output (m_axis_*), feeding the 100G MAC TX interface.
- Releases a packet only once it is completely received, so the MAC sees no bubbles inside a packet.
- Packets that overflow the buffer are dropped whole; no backpressure is applied upstream.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, tdata width in bits.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width in bits.
- DEPTH_LOG2, 6, log2 of buffer depth in beats (default 64 beats).

Ports:
- clk  in  1  clock for all logic.
- srst  in  1  synchronous reset, active-high.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input beat data, from the deparser.
- s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  input byte enables.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  input sideband.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  held 1 outside reset.
- s_axis_tlast  in  1  last beat of a packet.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  output beat data, to the MAC.
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  output byte enables.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  output sideband.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  output last beat.
- drop_count  out  32  packets dropped; saturates at 0xFFFFFFFF.
- tx_pkt_count  out  32  packets fully sent; wraps.

Behaviour:
- Storage: 2^DEPTH_LOG2 entries of {tdata, tuser, tkeep, tlast}.
- Pointers: wr_ptr (tentative), wr_commit, rd_ptr, each DEPTH_LOG2+1 bits. The extra bit is the wrap bit.
- full: (wr_ptr - rd_ptr) == 2^DEPTH_LOG2. Uncommitted beats count toward occupancy.
- pkt_avail: count of committed, unsent packets, DEPTH_LOG2+1 bits.
- Reset: while srst is high, all pointers, pkt_avail and counters are 0 and the write FSM is WR_IDLE. Reset values of outputs:
  - m_axis_tvalid=0, m_axis_tlast=0.
  - m_axis_tdata/tkeep/tuser=0.
  - s_axis_tready=0.
  - drop_count=0, tx_pkt_count=0.
- s_axis_tready=1 in every cycle after reset deasserts. A beat is accepted when s_axis_tvalid=1.
- Write FSM:
  - WR_IDLE, on an accepted beat:
    - if not full: store the beat, wr_ptr++.
    - if tlast: commit, stay in WR_IDLE.
    - if not tlast: go to WR_PKT.
    - if full: go to WR_DROP, or if tlast, drop the packet and stay in WR_IDLE.
  - WR_PKT, on an accepted beat:
    - if not full: store the beat, wr_ptr++. On tlast: commit and go to WR_IDLE.
    - if full: wr_ptr <= wr_commit (rollback), go to WR_DROP. If this beat has tlast, go to WR_IDLE instead.
    - Every drop increments drop_count.
  - WR_DROP: discard beats, wr_ptr is unchanged. On an accepted tlast go to WR_IDLE.
- Commit: wr_commit <= wr_ptr+1, pkt_avail++ (both on the same edge as the tlast beat is written).
- Consequence: a packet longer than 2^DEPTH_LOG2 beats is always dropped.
- Read path: one registered output stage plus a one-entry prefetch, so beats stream back to back.
- Start of a packet: a new packet starts only if pkt_avail>0 and the output stage is empty or completing (tvalid & tready & tlast).
- Minimum latency: tlast accepted at edge E0 → m_axis_tvalid=1 after edge E1.
- Within a packet, m_axis_tvalid stays 1 every cycle from the first to the last beat (no bubbles), independent of write activity.
- AXIS rules: once asserted, m_axis_tvalid and the data stay stable until m_axis_tready=1.
- End of packet: on the m_axis_tlast handshake, pkt_avail-- and tx_pkt_count++.
- Simultaneous commit and read completion in the same cycle: pkt_avail is unchanged.
- Pointer arithmetic: modulo 2^(DEPTH_LOG2+1); the memory index is the low DEPTH_LOG2 bits.
- srst asserted mid-packet:
  - Output is truncated: m_axis_tvalid goes to 0 on the next edge.
  - Partial input is discarded.
  - The first beat accepted after reset is treated as start of packet.

Optional Feature:
- Macro RMT_EGRESS_STATS_EN.
- Defined: drop_count and tx_pkt_count are live as specified above.
- Undefined: both ports are tied to 0 and the counter registers are not built. Datapath behaviour is identical.

Test Plan:
- Single 3-beat packet, m_axis_tready=1 → m_axis_tvalid rises the cycle after the tlast beat is accepted; 3 contiguous beats out, tlast on beat 3, data intact; tx_pkt_count=1.
- Two back-to-back 4-beat packets, m_axis_tready=1 → 8 contiguous output beats, no idle cycle between packets; tx_pkt_count=2.
- DEPTH_LOG2=6, one 70-beat packet → nothing is output, drop_count=1, buffer empty. A following 2-beat packet is forwarded intact.
- 60-beat packet committed with m_axis_tready=0, then a 10-beat packet arrives → second packet dropped (rollback), drop_count=1. Then m_axis_tready=1 → exactly 60 beats out; pointers return to equal.
- m_axis_tready toggling 1010 during a 5-beat packet → each beat is held stable while tready=0; 5 beats delivered in order; tlast only on beat 5.
- srst pulsed for one cycle while output is on beat 2 of 4 → m_axis_tvalid=0 the following cycle; counters=0. A fresh 1-beat packet afterwards is forwarded correctly.

Source files
------------

// File: rtl/rmt_egress_pkt_buffer.sv
// rmt_egress_pkt_buffer
//   Store-and-forward packet buffer between the RMT deparser output and the
//   100G MAC TX interface. A packet is released only after its last beat has
//   been written, so the MAC never sees a bubble inside a packet. Packets that
//   do not fit are dropped whole; the input is never backpressured.
//
//   Optional build macro: RMT_EGRESS_STATS_EN
//     defined   -> drop_count / tx_pkt_count are live counters
//     undefined -> both ports read 0 and no counter registers are built
//
//   Handshake semantics (both AXI-Stream ports): a beat transfers on a rising
//   clk edge where tvalid and tready are both 1. The input side has tready held
//   at 1 outside reset, so every s_axis_tvalid beat is taken. On the output
//   side, once m_axis_tvalid is 1 it and the beat payload stay unchanged until
//   the edge where m_axis_tready is 1.
//
//   wr_state_dbg exposes the write FSM state (0=WR_IDLE, 1=WR_PKT, 2=WR_DROP).
module rmt_egress_pkt_buffer #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_LOG2           = 6
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       drop_count,
  output logic [31:0]                       tx_pkt_count,
  output logic [1:0]                        wr_state_dbg
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int EW    = DW + UW + KW + 1;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_PKT  = 2'd1;
  localparam logic [1:0] WR_DROP = 2'd2;

  // Beat storage, entry layout {tlast, tuser, tkeep, tdata}
  logic [EW-1:0] mem [DEPTH];

  logic [1:0]    wr_state, wr_state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] wr_commit, wr_commit_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] pkt_avail;
  logic [PW-1:0] occupancy;
  logic          full;
  logic          beat_in;
  logic          mem_we;
  logic          commit;
  logic          out_done;
  logic          out_load;
  logic [EW-1:0] rd_entry;

  assign s_axis_tready = ~srst;
  assign beat_in       = s_axis_tvalid & ~srst;
  assign wr_state_dbg  = wr_state;

  // Uncommitted beats (wr_ptr ahead of wr_commit) count toward occupancy so a
  // packet in progress can never overwrite unread data.
  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == DEPTH_P);

  // Write FSM next state: store, commit on tlast, or roll back and drop
  always_comb begin
    wr_state_nxt  = wr_state;
    wr_ptr_nxt    = wr_ptr;
    wr_commit_nxt = wr_commit;
    mem_we        = 1'b0;
    commit        = 1'b0;
    if (beat_in) begin
      case (wr_state)
        WR_IDLE, WR_PKT: begin
          if (!full) begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + ONE_P;
            if (s_axis_tlast) begin
              commit        = 1'b1;
              wr_commit_nxt = wr_ptr + ONE_P;
              wr_state_nxt  = WR_IDLE;
            end else begin
              wr_state_nxt = WR_PKT;
            end
          end else begin
            // In WR_IDLE wr_commit already equals wr_ptr, so this rollback
            // only has an effect for a packet that was partly written.
            wr_ptr_nxt   = wr_commit;
            wr_state_nxt = s_axis_tlast ? WR_IDLE : WR_DROP;
          end
        end
        WR_DROP: begin
          if (s_axis_tlast) wr_state_nxt = WR_IDLE;
        end
        default: wr_state_nxt = WR_IDLE;
      endcase
    end
  end

  // Write FSM and write-side pointer registers
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_state  <= WR_IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      wr_state  <= wr_state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      wr_commit <= wr_commit_nxt;
    end
  end

  // Beat storage write port
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  end

  // The entry at rd_ptr is the prefetched next beat: it is always readable in
  // the cycle before it is needed, so the output register can be reloaded on
  // every handshake without a bubble.
  assign rd_entry = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // A new packet may start only when the output is empty or is completing its
  // last beat. In the completing case the packet in flight is still counted in
  // pkt_avail, so another committed packet exists only when pkt_avail > 1.
  // Inside a packet the next beat is always committed, so it loads directly.
  assign out_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign out_load = (!m_axis_tvalid && (pkt_avail != '0)) ||
                    (m_axis_tvalid && m_axis_tready && (!m_axis_tlast || (pkt_avail > ONE_P)));

  // Registered output stage and read pointer
  always_ff @(posedge clk) begin
    if (srst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      rd_ptr        <= '0;
    end else if (out_load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= rd_entry[DW-1:0];
      m_axis_tkeep  <= rd_entry[DW +: KW];
      m_axis_tuser  <= rd_entry[DW+KW +: UW];
      m_axis_tlast  <= rd_entry[EW-1];
      rd_ptr        <= rd_ptr + ONE_P;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

  // Committed-but-unsent packet count; commit and completion together cancel
  always_ff @(posedge clk) begin
    if (srst) begin
      pkt_avail <= '0;
    end else if (commit && !out_done) begin
      pkt_avail <= pkt_avail + ONE_P;
    end else if (!commit && out_done) begin
      pkt_avail <= pkt_avail - ONE_P;
    end
  end

`ifdef RMT_EGRESS_STATS_EN
  logic        drop;
  logic [31:0] drop_q;
  logic [31:0] tx_q;

  // One drop per packet: the first beat that finds the buffer full outside WR_DROP
  assign drop = beat_in & full & (wr_state != WR_DROP);

  // Drop counter saturates, transmitted-packet counter wraps
  always_ff @(posedge clk) begin
    if (srst) begin
      drop_q <= '0;
      tx_q   <= '0;
    end else begin
      if (drop && (drop_q != 32'hFFFF_FFFF)) drop_q <= drop_q + 32'd1;
      if (out_done) tx_q <= tx_q + 32'd1;
    end
  end

  assign drop_count   = drop_q;
  assign tx_pkt_count = tx_q;
`else
  assign drop_count   = 32'd0;
  assign tx_pkt_count = 32'd0;
`endif

endmodule
